// File: rtl/mul_seq.sv
// Sequential 8x8 unsigned shift-add multiplier that borrows an external ALU for its adds.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips RUN and finishes in one cycle.
module mul_seq #(
  parameter int ITERS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_code,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  localparam int            CW   = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  if (ITERS != 8) begin : g_iters_chk
    $error("mul_seq: only ITERS=8 is supported");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [7:0]    p;
  logic [7:0]    m;
  logic [7:0]    mcand;
  logic [CW-1:0] cnt;
  logic [15:0]   pm_next;
  logic          zero_op;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (op_a == 8'h00) || (op_b == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  // {carry, sum, M} shifted right by one; the bit shifted out of M is consumed.
  assign pm_next  = {alu_carry, alu_out, m[7:1]};

  assign alu_code = 3'b000;
  assign alu_a    = (state == RUN) ? p : 8'h00;
  assign alu_b    = (state == RUN && m[0]) ? mcand : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      p       <= '0;
      m       <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            m     <= op_b;
            p     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (zero_op) begin
              state   <= DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          {p, m} <= pm_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            product <= pm_next;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: models the ALU, compares against a*b and the cycle timing.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_code;
  logic        alu_carry;
  logic [8:0]  alu_sum;

  int tests = 0;
  int fails = 0;

  logic        done_log [0:63];
  logic        busy_log [0:63];
  logic [15:0] prod_log [0:63];
  int          ndone;
  int          first_done;
  bit          carry_seen;

  mul_seq #(.ITERS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Environment ALU: ADD only, combinational.
  assign alu_sum   = (alu_code == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 9'h000;
  assign alu_out   = alu_sum[7:0];
  assign alu_carry = alu_sum[8];

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 8'h00 || b == 8'h00) return 1;
`endif
    return 9;
  endfunction

  // Accept edge is cycle 0; operands are scrambled right after acceptance.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
  endtask

  // Records cycles 1..ncyc; optional start pulse and reset cycle.
  task automatic watch(input int ncyc, input int pulse_at, input logic [7:0] pa,
                       input logic [7:0] pb, input int rst_at);
    ndone = 0; first_done = -1; carry_seen = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      done_log[n] = done; busy_log[n] = busy; prod_log[n] = product;
      if (busy && alu_carry) carry_seen = 1;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      start = (n == pulse_at);
      if (n == pulse_at) begin op_a = pa; op_b = pb; end
      rst_n = (n != rst_at);
    end
    start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; op_a = 8'd5; op_b = 8'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL reset_product got=%h exp=0000", product); end
    tests++; if ({alu_a, alu_b, alu_code} !== 19'h0) begin fails++;
      $display("FAIL reset_alu got=%h/%h/%b exp=0/0/000", alu_a, alu_b, alu_code); end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed;
    int bad = 0;
    issue(8'd13, 8'd11);
    watch(14, -1, 8'd0, 8'd0, -1);
    tests++; if (first_done != 9 || ndone != 1) begin fails++;
      $display("FAIL d13x11_done got cycle=%0d count=%0d exp cycle=9 count=1", first_done, ndone); end
    tests++; if (prod_log[9] !== 16'h008F) begin fails++;
      $display("FAIL d13x11_product got=%h exp=008f", prod_log[9]); end
    for (int n = 1; n <= 10; n++) if (busy_log[n] !== (n <= 9)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL d13x11_busy got=%0d bad cycles exp=0", bad); end
    bad = 0;
    for (int n = 1; n <= 8; n++) if (prod_log[n] !== 16'h0000) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL d13x11_hold_run got=%0d bad cycles exp=0", bad); end
    tests++; if (prod_log[14] !== 16'h008F) begin fails++;
      $display("FAIL d13x11_hold_after got=%h exp=008f", prod_log[14]); end
  endtask

  task automatic test_max;
    issue(8'd255, 8'd255);
    watch(11, -1, 8'd0, 8'd0, -1);
    tests++; if (first_done != 9 || prod_log[9] !== 16'hFE01) begin fails++;
      $display("FAIL max_product got=%h@%0d exp=fe01@9", prod_log[9], first_done); end
    tests++; if (!carry_seen) begin fails++; $display("FAIL max_carry got=0 exp=1"); end
  endtask

  task automatic test_zero;
    int lat = exp_lat(8'd0, 8'd77);
    issue(8'd0, 8'd77);
    watch(11, -1, 8'd0, 8'd0, -1);
    tests++; if (first_done != lat || ndone != 1) begin fails++;
      $display("FAIL zero_latency got=%0d count=%0d exp=%0d count=1", first_done, ndone, lat); end
    tests++; if (prod_log[lat] !== 16'h0000) begin fails++;
      $display("FAIL zero_product got=%h exp=0000", prod_log[lat]); end
  endtask

  task automatic test_start_ignored;
    issue(8'd6, 8'd7);
    watch(20, 4, 8'd9, 8'd9, -1);
    tests++; if (ndone != 1 || first_done != 9) begin fails++;
      $display("FAIL restart_done got count=%0d cycle=%0d exp count=1 cycle=9", ndone, first_done); end
    tests++; if (prod_log[9] !== 16'd42 || prod_log[20] !== 16'd42) begin fails++;
      $display("FAIL restart_product got=%0d/%0d exp=42/42", prod_log[9], prod_log[20]); end
  endtask

  task automatic test_reset_abort;
    issue(8'd200, 8'd3);
    watch(14, -1, 8'd0, 8'd0, 5);
    tests++; if (ndone != 0) begin fails++; $display("FAIL abort_done got count=%0d exp=0", ndone); end
    tests++; if (prod_log[14] !== 16'h0000 || busy_log[14] !== 1'b0) begin fails++;
      $display("FAIL abort_state got product=%h busy=%b exp=0000/0", prod_log[14], busy_log[14]); end
    issue(8'd2, 8'd2);
    watch(11, -1, 8'd0, 8'd0, -1);
    tests++; if (first_done != 9 || prod_log[9] !== 16'd4) begin fails++;
      $display("FAIL abort_recover got=%0d@%0d exp=4@9", prod_log[9], first_done); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  a, b;
      logic [15:0] prev;
      int lat, bad;
      a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(7) == 0) a = 8'h00;
      if ($urandom_range(7) == 0) b = 8'h00;
      lat = exp_lat(a, b);
      prev = product;
      issue(a, b);
      watch(lat + 2, -1, 8'd0, 8'd0, -1);
      tests++; if (first_done != lat || ndone != 1 || prod_log[lat] !== 16'(a * b)) begin fails++;
        $display("FAIL rand_%0d %0d*%0d got=%0d@%0d count=%0d exp=%0d@%0d", i, a, b,
                 prod_log[lat], first_done, ndone, 16'(a * b), lat); end
      bad = 0;
      for (int n = 1; n < lat; n++) if (prod_log[n] !== prev) bad++;
      tests++; if (bad != 0) begin fails++;
        $display("FAIL rand_hold_%0d got=%0d bad cycles exp=0", i, bad); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] expq [$];
    int last = 0, seen = 0;
    @(negedge clk);
    op_a = 8'($urandom_range(255, 1)); op_b = 8'($urandom_range(255, 1));
    expq.push_back(16'(op_a * op_b));
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        seen++;
        tests++; if (c - last != (seen == 1 ? 9 : 10)) begin fails++;
          $display("FAIL b2b_period_%0d got=%0d exp=%0d", seen, c - last, (seen == 1 ? 9 : 10)); end
        tests++; if (expq.size() == 0 || product !== expq[0]) begin fails++;
          $display("FAIL b2b_product_%0d got=%h exp=%h", seen, product,
                   (expq.size() == 0) ? 16'hxxxx : expq[0]); end
        if (expq.size() != 0) void'(expq.pop_front());
        last = c;
        op_a = 8'($urandom_range(255, 1)); op_b = 8'($urandom_range(255, 1));
        expq.push_back(16'(op_a * op_b));
      end
    end
    start = 1'b0;
    tests++; if (seen != 4) begin fails++; $display("FAIL b2b_count got=%0d exp=4", seen); end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    test_reset;
    test_directed;
    test_max;
    test_zero;
    test_start_ignored;
    test_reset_abort;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
